ex_seq_ctrl: RTL and testbench
==============================

# ex_seq_ctrl

Execute-stage sequencer between the ID/EX boundary and the shared ALU. Accepts decoded ops with a valid/ready handshake and drives the ALU directly for single-cycle ops. Runs an iterative shift-add multiply that reuses the ALU adder over DATA_WIDTH cycles. Registers the result, destination, and write-enable toward LSU/WB with its own valid/ready handshake.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, op code width; ADD = 4'h0, SUB = 4'h1, MUL = 4'h8 (low DATA_WIDTH bits of product)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- id_valid  in  1  ID presents an op
- id_ready  out  1  controller accepts this cycle
- id_op  in  OP_WIDTH  operation
- id_oprand1, id_oprand2  in  DATA_WIDTH  operands
- id_rd_wr_addr  in  5  destination register
- id_rd_wr_en  in  1  destination write enable
- alu_op  out  OP_WIDTH  to ALU
- alu_oprand1, alu_oprand2  out  DATA_WIDTH  to ALU
- alu_result  in  DATA_WIDTH  from ALU (combinational)
- ex_valid  out  1  result valid downstream
- ex_ready  in  1  downstream accepts
- ex_result  out  DATA_WIDTH  registered result
- ex_rd_wr_addr  out  5  registered destination
- ex_rd_wr_en  out  1  registered write enable
- busy  out  1  multiply in progress

## Operation
- States: IDLE (no result held), MUL (iterating), HOLD (result held, ex_valid = 1).
- id_ready = !flush && (state == IDLE || (state == HOLD && ex_ready)).
- Accept occurs when id_valid && id_ready.
- ALU muxing:
  - In MUL: alu_op = ADD, alu_oprand1 = acc, alu_oprand2 = mplier[0] ? mcand : 0.
  - Otherwise: alu_op/alu_oprand1/alu_oprand2 pass id_op/id_oprand1/id_oprand2 through.
- Accept of ADD/SUB:
  - ex_result <= alu_result; ex_rd_wr_* <= id_rd_wr_*; state -> HOLD.
- Accept of MUL:
  - mcand <= id_oprand1; mplier <= id_oprand2; acc <= 0; cnt <= 0; destination latched; state -> MUL.
- Each MUL cycle:
  - acc <= alu_result; mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - On cnt == DATA_WIDTH-1: ex_result <= alu_result; state -> HOLD.
- Arithmetic: all modulo 2^DATA_WIDTH; overflow is discarded and no flags are produced.
- HOLD with ex_ready:
  - Result retires.
  - A same-cycle accept loads the next op (back-to-back, no bubble).
  - With no accept, state -> IDLE.
- HOLD without ex_ready: all ex_* outputs are stable.
- Unknown op codes: treated as single-cycle, result = alu_result.
- busy = (state == MUL).
- flush:
  - Has priority over everything.
  - Next state IDLE; ex_valid = 0; in-flight multiply is discarded.
  - No accept in the flush cycle.
- Reset values (async on rst_n low):
  - state = IDLE; ex_valid = 0; ex_result = 0; ex_rd_wr_addr = 0; ex_rd_wr_en = 0; busy = 0; acc = mcand = mplier = cnt = 0.
- Reset mid-multiply aborts with no output.

## Timing
- ADD/SUB: accepted at edge E; ex_valid = 1 after E. Latency 1.
- MUL: accepted at edge E; iterations on edges E+1..E+DATA_WIDTH; ex_valid = 1 after E+DATA_WIDTH. Latency DATA_WIDTH.
- Throughput: 1 op/cycle for ADD/SUB with ex_ready held high; MUL blocks input for DATA_WIDTH cycles (id_ready = 0 while busy).
- Combinational paths id_* → alu_* → alu_result → ex_result register exist only outside the MUL state.

## Configuration
- EX_ITER_MUL_EN defined:
  - Iterative multiplier and MUL state are present, as described above.
- EX_ITER_MUL_EN undefined:
  - No MUL state, acc/mcand/mplier/cnt are removed, and busy is tied to 0.
  - MUL is treated as illegal: it completes in 1 cycle with ex_result = 0 and ex_rd_wr_en forced to 0.

## Test plan
- Reset: rst_n low for 3 cycles with random inputs → ex_valid = 0, ex_result = 0, busy = 0, id_ready = 1 after release.
- Back-to-back ALU ops with ex_ready = 1: ADD 5+7, SUB 3−5, ADD 0xFFFFFFFF+1 → ex_result = 12, 0xFFFFFFFE, 0 on consecutive cycles; id_ready stays 1.
- MUL 0x1234 × 0x10 (DATA_WIDTH = 32) → busy for 32 cycles, id_ready = 0 throughout, ex_valid after 32 cycles with result 0x12340; MUL 0xFFFFFFFF × 0xFFFFFFFF → 1.
- Backpressure: ex_ready = 0 for 4 cycles after an ADD result → ex_* stable, id_ready = 0; on ex_ready = 1 with a pending id_valid, the next op is loaded the same edge.
- Flush asserted at iteration 10 of a MUL → next cycle state IDLE, ex_valid = 0, busy = 0, no result emitted; the following ADD 1+1 yields 2.
- EX_ITER_MUL_EN undefined: MUL 3 × 4 → ex_valid after 1 cycle, ex_result = 0, ex_rd_wr_en = 0.

Source files
------------

// File: rtl/ex_seq_ctrl.sv
// ex_seq_ctrl: execute-stage sequencer between ID/EX and the shared ALU.
// Single-cycle ops are steered straight through the external ALU. MUL runs
// an iterative shift-add that reuses the ALU adder for DATA_WIDTH cycles.
// The result, destination and write enable are registered toward LSU/WB.
//
// Configuration macro: EX_ITER_MUL_EN
//   defined   - iterative multiplier and MUL state present
//   undefined - MUL is illegal: 1-cycle completion, ex_result = 0,
//               ex_rd_wr_en = 0, busy tied low
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous flush (highest priority)
//   id_valid/id_ready     ID handshake; id_op, id_oprand1/2, id_rd_wr_addr/en
//   alu_op, alu_oprand1/2 operands to the combinational ALU
//   alu_result            ALU result
//   ex_valid/ex_ready     downstream handshake
//   ex_result, ex_rd_wr_addr, ex_rd_wr_en   registered outputs
//   busy                  multiply in progress
module ex_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [OP_WIDTH-1:0]   id_op,
    input  logic [DATA_WIDTH-1:0] id_oprand1,
    input  logic [DATA_WIDTH-1:0] id_oprand2,
    input  logic [4:0]            id_rd_wr_addr,
    input  logic                  id_rd_wr_en,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_oprand1,
    output logic [DATA_WIDTH-1:0] alu_oprand2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_result,
    output logic [4:0]            ex_rd_wr_addr,
    output logic                  ex_rd_wr_en,
    output logic                  busy
);

    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8);
`ifdef EX_ITER_MUL_EN
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef EX_ITER_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_HOLD = 2'd2
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] ex_result_q;
    logic [4:0]            ex_addr_q;
    logic                  ex_en_q;
    logic                  accept_c;

`ifdef EX_ITER_MUL_EN
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0]      cnt_q;
`endif

    // Input handshake: a held result may be replaced in the cycle it retires.
    always_comb begin
        id_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && ex_ready));
        accept_c = id_valid && id_ready;
    end

    // ALU steering: the multiplier borrows the adder while iterating.
    always_comb begin
        alu_op      = id_op;
        alu_oprand1 = id_oprand1;
        alu_oprand2 = id_oprand2;
`ifdef EX_ITER_MUL_EN
        if (state_q == S_MUL) begin
            alu_op      = OP_ADD;
            alu_oprand1 = acc_q;
            alu_oprand2 = mplier_q[0] ? mcand_q : '0;
        end
`endif
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ex_result_q <= '0;
            ex_addr_q   <= '0;
            ex_en_q     <= 1'b0;
`ifdef EX_ITER_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
        end else if (accept_c) begin
            ex_addr_q <= id_rd_wr_addr;
`ifdef EX_ITER_MUL_EN
            if (id_op == OP_MUL) begin
                state_q  <= S_MUL;
                acc_q    <= '0;
                mcand_q  <= id_oprand1;
                mplier_q <= id_oprand2;
                cnt_q    <= '0;
                ex_en_q  <= id_rd_wr_en;
            end else begin
                state_q     <= S_HOLD;
                ex_result_q <= alu_result;
                ex_en_q     <= id_rd_wr_en;
            end
`else
            state_q <= S_HOLD;
            // MUL is illegal without the multiplier: zero result, no writeback.
            if (id_op == OP_MUL) begin
                ex_result_q <= '0;
                ex_en_q     <= 1'b0;
            end else begin
                ex_result_q <= alu_result;
                ex_en_q     <= id_rd_wr_en;
            end
`endif
        end else if (state_q == S_HOLD) begin
            if (ex_ready) begin
                state_q <= S_IDLE;
            end
        end
`ifdef EX_ITER_MUL_EN
        else if (state_q == S_MUL) begin
            acc_q    <= alu_result;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                ex_result_q <= alu_result;
                state_q     <= S_HOLD;
            end
        end
`endif
    end

    assign ex_valid      = (state_q == S_HOLD);
    assign ex_result     = ex_result_q;
    assign ex_rd_wr_addr = ex_addr_q;
    assign ex_rd_wr_en   = ex_en_q;
`ifdef EX_ITER_MUL_EN
    assign busy          = (state_q == S_MUL);
`else
    assign busy          = 1'b0;
`endif

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Self-checking bench for ex_seq_ctrl with a behavioural ALU and a
// result/latency reference model. Works with or without EX_ITER_MUL_EN.
module tb_ex_seq_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 4;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h8;
`ifdef EX_ITER_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [OW-1:0] id_op;
    logic [DW-1:0] id_oprand1, id_oprand2;
    logic [4:0]    id_rd_wr_addr;
    logic          id_rd_wr_en;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_oprand1, alu_oprand2, alu_result;
    logic          ex_valid, ex_ready;
    logic [DW-1:0] ex_result;
    logic [4:0]    ex_rd_wr_addr;
    logic          ex_rd_wr_en;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU; unknown codes produce a distinctive mix of the operands.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_oprand1 + alu_oprand2;
            OP_SUB:  alu_result = alu_oprand1 - alu_oprand2;
            default: alu_result = alu_oprand1 ^ ~alu_oprand2;
        endcase
    end

    ex_seq_ctrl #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_oprand1(id_oprand1), .id_oprand2(id_oprand2),
        .id_rd_wr_addr(id_rd_wr_addr), .id_rd_wr_en(id_rd_wr_en),
        .alu_op(alu_op), .alu_oprand1(alu_oprand1), .alu_oprand2(alu_oprand2),
        .alu_result(alu_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_rd_wr_addr(ex_rd_wr_addr), .ex_rd_wr_en(ex_rd_wr_en), .busy(busy)
    );

    // Reference model: what the stage must deliver for one op.
    function automatic logic [DW-1:0] model_result(input logic [3:0] op,
                                                   input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b);
        logic [DW-1:0] r;
        if (op == OP_ADD)      r = a + b;
        else if (op == OP_SUB) r = a - b;
        else if (op == OP_MUL) r = MUL_EN ? a * b : '0;
        else                   r = a ^ ~b;
        return r;
    endfunction

    function automatic logic model_en(input logic [3:0] op, input logic en);
        return (op == OP_MUL && !MUL_EN) ? 1'b0 : en;
    endfunction

    // Edges after the accept edge before ex_valid appears.
    function automatic int model_iters(input logic [3:0] op);
        return (op == OP_MUL && MUL_EN) ? int'(DW) : 0;
    endfunction

    task automatic randomize_id();
        id_op         = 4'($urandom);
        id_oprand1    = $urandom;
        id_oprand2    = $urandom;
        id_rd_wr_addr = 5'($urandom);
        id_rd_wr_en   = 1'($urandom);
    endtask

    // Present one op at a negedge, then wait (bounded) for ex_valid.
    task automatic issue_op(input logic [3:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [4:0] rd,
                            input logic en, output logic rdy, output int iters,
                            output int busy_n, output int open_n);
        id_op = op; id_oprand1 = a; id_oprand2 = b;
        id_rd_wr_addr = rd; id_rd_wr_en = en; id_valid = 1'b1;
        #1 rdy = id_ready;
        @(negedge clk);
        id_valid = 1'b0;
        randomize_id();
        iters = 0; busy_n = 0; open_n = 0;
        while (ex_valid !== 1'b1 && iters < 200) begin
            if (busy === 1'b1) busy_n++;
            if (id_ready !== 1'b0) open_n++;
            @(negedge clk);
            iters++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'($urandom); id_valid = 1'($urandom);
        ex_ready = 1'($urandom); randomize_id();
        repeat (3) begin
            @(negedge clk);
            checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
            checks++; if (ex_result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", ex_result); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++; if (ex_rd_wr_en !== 1'b0 || ex_rd_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_dest: got en=%b addr=%0d expected 0/0", ex_rd_wr_en, ex_rd_wr_addr); end
            flush = 1'($urandom); id_valid = 1'($urandom); ex_ready = 1'($urandom); randomize_id();
        end
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %b expected 1", id_ready); end
    endtask

    task automatic test_alu_b2b();
        logic [DW-1:0] av [3];
        logic [DW-1:0] bv [3];
        logic [3:0]    ov [3];
        logic [DW-1:0] rv [3];
        av = '{32'd5, 32'd3, 32'hFFFF_FFFF};
        bv = '{32'd7, 32'd5, 32'd1};
        ov = '{OP_ADD, OP_SUB, OP_ADD};
        rv = '{32'd12, 32'hFFFF_FFFE, 32'd0};
        @(negedge clk);
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_op = ov[i]; id_oprand1 = av[i]; id_oprand2 = bv[i];
            id_rd_wr_addr = 5'(i + 1); id_rd_wr_en = (i != 2); id_valid = 1'b1;
            #1;
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_id_ready[%0d]: got %b expected 1", i, id_ready); end
            @(negedge clk);
            checks++; if (ex_valid !== 1'b1 || ex_result !== rv[i]) begin errors++; $display("FAIL b2b_result[%0d]: got v=%b %h expected 1 %h", i, ex_valid, ex_result, rv[i]); end
            checks++; if (ex_rd_wr_addr !== 5'(i + 1) || ex_rd_wr_en !== (i != 2)) begin errors++; $display("FAIL b2b_dest[%0d]: got %0d/%b", i, ex_rd_wr_addr, ex_rd_wr_en); end
        end
        id_valid = 1'b0;
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", ex_valid); end
    endtask

    task automatic test_mul();
        logic [DW-1:0] av [3];
        logic [DW-1:0] bv [3];
        logic rdy; int it, bn, on;
        av = '{32'h1234, 32'hFFFF_FFFF, 32'd3};
        bv = '{32'h10, 32'hFFFF_FFFF, 32'd4};
        @(negedge clk);
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_op(OP_MUL, av[i], bv[i], 5'(10 + i), 1'b1, rdy, it, bn, on);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mul_accept[%0d]: id_ready=%b expected 1", i, rdy); end
            checks++; if (it != model_iters(OP_MUL)) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, it, model_iters(OP_MUL)); end
            checks++; if (bn != model_iters(OP_MUL) || on != 0) begin errors++; $display("FAIL mul_busy[%0d]: busy cycles %0d ready-open %0d expected %0d/0", i, bn, on, model_iters(OP_MUL)); end
            checks++; if (ex_result !== model_result(OP_MUL, av[i], bv[i])) begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, ex_result, model_result(OP_MUL, av[i], bv[i])); end
            checks++; if (ex_rd_wr_en !== model_en(OP_MUL, 1'b1) || ex_rd_wr_addr !== 5'(10 + i)) begin errors++; $display("FAIL mul_dest[%0d]: got %0d/%b", i, ex_rd_wr_addr, ex_rd_wr_en); end
        end
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_drain: valid=%b busy=%b expected 0/0", ex_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic rdy; int it, bn, on;
        logic [DW-1:0] a, b, c, d, exp1, exp2;
        logic [4:0] rd1;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom; rd1 = 5'($urandom);
        exp1 = model_result(OP_ADD, a, b);
        exp2 = model_result(OP_SUB, c, d);
        @(negedge clk);
        ex_ready = 1'b0;
        issue_op(OP_ADD, a, b, rd1, 1'b1, rdy, it, bn, on);
        checks++; if (rdy !== 1'b1 || it != 0) begin errors++; $display("FAIL bp_first: rdy=%b iters=%0d expected 1/0", rdy, it); end
        id_op = OP_SUB; id_oprand1 = c; id_oprand2 = d; id_rd_wr_addr = 5'd31; id_rd_wr_en = 1'b1; id_valid = 1'b1;
        repeat (4) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_id_ready: got %b expected 0", id_ready); end
            checks++; if (ex_valid !== 1'b1 || ex_result !== exp1 || ex_rd_wr_addr !== rd1 || ex_rd_wr_en !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b %h %0d %b expected 1 %h %0d 1", ex_valid, ex_result, ex_rd_wr_addr, ex_rd_wr_en, exp1, rd1); end
            @(negedge clk);
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", id_ready); end
        @(negedge clk);
        id_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_result !== exp2 || ex_rd_wr_addr !== 5'd31) begin errors++; $display("FAIL bp_next: got %b %h %0d expected 1 %h 31", ex_valid, ex_result, ex_rd_wr_addr, exp2); end
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", ex_valid); end
    endtask

    task automatic test_flush();
        logic rdy; int it, bn, on, seen;
        @(negedge clk);
        ex_ready = 1'b1;
        id_op = OP_MUL; id_oprand1 = $urandom; id_oprand2 = $urandom;
        id_rd_wr_addr = 5'd9; id_rd_wr_en = 1'b1; id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_id_ready: got %b expected 0", id_ready); end
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL flush_mul_abort: busy=%b valid=%b expected 0/0", busy, ex_valid); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ex_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: saw %0d valid cycles expected 0", seen); end
        issue_op(OP_ADD, 32'd1, 32'd1, 5'd4, 1'b1, rdy, it, bn, on);
        checks++; if (rdy !== 1'b1 || ex_result !== 32'd2) begin errors++; $display("FAIL flush_after_add: rdy=%b result=%h expected 1 2", rdy, ex_result); end
        // Flush while a result is held and another op is waiting.
        ex_ready = 1'b0;
        @(negedge clk);
        id_op = OP_SUB; id_oprand1 = 32'd50; id_oprand2 = 32'd8; id_rd_wr_addr = 5'd6; id_valid = 1'b1;
        flush = 1'b1; ex_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_hold_ready: got %b expected 0", id_ready); end
        @(negedge clk);
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_valid: got %b expected 0", ex_valid); end
        @(negedge clk);
        id_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_result !== 32'd42) begin errors++; $display("FAIL flush_hold_next: got %b %h expected 1 2a", ex_valid, ex_result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        @(negedge clk);
        ex_ready = 1'b0;
        id_op = OP_MUL; id_oprand1 = $urandom | 32'h1; id_oprand2 = $urandom | 32'h1;
        id_rd_wr_addr = 5'd3; id_rd_wr_en = 1'b1; id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ex_valid !== 1'b0 || ex_result !== '0 || ex_rd_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_mul: busy=%b valid=%b result=%h en=%b expected 0", busy, ex_valid, ex_result, ex_rd_wr_en); end
        @(negedge clk);
        rst_n = 1'b1; ex_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ex_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_mul_quiet: %0d active cycles expected 0", seen); end
    endtask

    task automatic test_random();
        logic rdy; int it, bn, on, stall;
        logic [3:0] op;
        logic [DW-1:0] a, b, exp_r;
        logic [4:0] rd;
        logic en, exp_en;
        @(negedge clk);
        for (int n = 0; n < 150; n++) begin
            case ($urandom % 4)
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_MUL;
                default: op = 4'($urandom);
            endcase
            a = ($urandom % 3 == 0) ? 32'($urandom % 16) : $urandom;
            b = ($urandom % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
            rd = 5'($urandom); en = 1'($urandom);
            exp_r = model_result(op, a, b);
            exp_en = model_en(op, en);
            ex_ready = 1'b1;
            issue_op(op, a, b, rd, en, rdy, it, bn, on);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rnd_accept[%0d]: got %b expected 1", n, rdy); end
            checks++; if (it != model_iters(op) || bn != model_iters(op) || on != 0) begin errors++; $display("FAIL rnd_timing[%0d] op=%h: iters=%0d busy=%0d open=%0d expected %0d", n, op, it, bn, on, model_iters(op)); end
            checks++; if (ex_result !== exp_r || ex_rd_wr_addr !== rd || ex_rd_wr_en !== exp_en) begin errors++; $display("FAIL rnd_result[%0d] op=%h a=%h b=%h: got %h %0d %b expected %h %0d %b", n, op, a, b, ex_result, ex_rd_wr_addr, ex_rd_wr_en, exp_r, rd, exp_en); end
            stall = $urandom % 4;
            if (stall > 0) begin
                ex_ready = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    checks++; if (ex_valid !== 1'b1 || ex_result !== exp_r) begin errors++; $display("FAIL rnd_stall[%0d]: got %b %h expected 1 %h", n, ex_valid, ex_result, exp_r); end
                end
                ex_ready = 1'b1;
            end
        end
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b expected 0", ex_valid); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_b2b();
        test_mul();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
